// File: rtl/text_console_writer.sv
// Byte-stream text console: renders characters into the 160x45 text-mode BRAM,
// tracks the cursor, and scrolls/clears the screen by word-wise copy and fill.
module text_console_writer #(
  parameter int unsigned COLS         = 160,
  parameter int unsigned ROWS         = 45,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk_hdmi_in,
  input  logic        rst_in,
  input  logic [7:0]  char_in,
  input  logic [7:0]  attr_in,
  input  logic        char_valid_in,
  output logic        char_ready_out,
  output logic [7:0]  cursor_col_out,
  output logic [5:0]  cursor_row_out,
  output logic        busy_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  mem_write_enable_out,
  input  logic [31:0] mem_data_in
);

  localparam int unsigned WORDS_PER_ROW = COLS / 2;
  localparam logic [11:0] ROW_WORDS  = 12'(WORDS_PER_ROW);
  localparam logic [11:0] LAST_WORD  = 12'(ROWS * WORDS_PER_ROW - 1);
  localparam logic [11:0] BLANK_BASE = 12'((ROWS - 1) * WORDS_PER_ROW);
  localparam logic [7:0]  LAST_COL   = 8'(COLS - 1);
  localparam logic [5:0]  LAST_ROW   = 6'(ROWS - 1);
  localparam logic [7:0]  LAST_WAIT  = 8'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, CELL, SCROLL_RD, SCROLL_WAIT, SCROLL_WR, FILL
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  char_q, attr_q;
  logic [7:0]  col;
  logic [5:0]  row;
  logic [11:0] ptr;
  logic [7:0]  wait_cnt;
  logic [31:0] data_q;
  logic        clear_q;
  logic [11:0] addr;

  logic        printable, is_lf, is_cr, is_bs, is_ff, need_scroll;
  logic [11:0] cell_word;

  assign printable   = (char_q >= 8'h20) && (char_q != 8'h7F);
  assign is_lf       = (char_q == 8'h0A);
  assign is_cr       = (char_q == 8'h0D);
  assign is_bs       = (char_q == 8'h08);
  assign is_ff       = (char_q == 8'h0C);
  assign cell_word   = 12'(row) * ROW_WORDS + 12'(col[7:1]);
  // A wrap off the last column of the last row scrolls exactly like LF there.
  assign need_scroll = (row == LAST_ROW) && (is_lf || (printable && col == LAST_COL));

  assign cursor_col_out = col;
  assign cursor_row_out = row;
  assign mem_addr_out   = {20'b0, addr};

  always_ff @(posedge clk_hdmi_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d              = state_q;
    char_ready_out       = 1'b0;
    busy_out             = 1'b0;
    addr                 = '0;
    mem_data_out         = '0;
    mem_write_enable_out = '0;
    case (state_q)
      IDLE: begin
        char_ready_out = !rst_in;
        if (char_valid_in) state_d = CELL;
      end
      CELL: begin
        if (printable) begin
          addr                 = cell_word;
          mem_data_out         = {attr_q, char_q, attr_q, char_q};
          mem_write_enable_out = col[0] ? 4'b1100 : 4'b0011;
        end
        if (need_scroll) state_d = SCROLL_RD;
        else if (is_ff)  state_d = FILL;
        else             state_d = IDLE;
      end
      SCROLL_RD: begin
        busy_out = 1'b1;
        addr     = ptr;
        state_d  = SCROLL_WAIT;
      end
      SCROLL_WAIT: begin
        busy_out = 1'b1;
        addr     = ptr;
        if (wait_cnt == LAST_WAIT) state_d = SCROLL_WR;
      end
      SCROLL_WR: begin
        busy_out             = 1'b1;
        addr                 = ptr - ROW_WORDS;
        mem_data_out         = data_q;
        mem_write_enable_out = 4'hF;
        state_d              = (ptr == LAST_WORD) ? FILL : SCROLL_RD;
      end
      FILL: begin
        busy_out             = 1'b1;
        addr                 = ptr;
        mem_write_enable_out = 4'hF;
        if (ptr == LAST_WORD) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_hdmi_in or posedge rst_in) begin
    if (rst_in) begin
      char_q   <= '0;
      attr_q   <= '0;
      col      <= '0;
      row      <= '0;
      ptr      <= '0;
      wait_cnt <= '0;
      data_q   <= '0;
      clear_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (char_valid_in) begin
            char_q <= char_in;
            attr_q <= attr_in;
          end
        end
        CELL: begin
          if (printable || is_lf) begin
            if (is_lf || col == LAST_COL) begin
              col <= '0;
              if (row != LAST_ROW) row <= row + 6'd1;
            end else begin
              col <= col + 8'd1;
            end
          end else if (is_cr) begin
            col <= '0;
          end else if (is_bs && col != 8'd0) begin
            col <= col - 8'd1;
          end
          // ptr seeds either the scroll source (row 1) or the full-screen clear.
          if (is_ff && !need_scroll) begin
            ptr     <= '0;
            clear_q <= 1'b1;
          end else begin
            ptr     <= ROW_WORDS;
            clear_q <= 1'b0;
          end
          wait_cnt <= '0;
        end
        SCROLL_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            data_q   <= mem_data_in;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        SCROLL_WR: ptr <= (ptr == LAST_WORD) ? BLANK_BASE : ptr + 12'd1;
        FILL: begin
          ptr <= ptr + 12'd1;
          if (ptr == LAST_WORD && clear_q) begin
            col <= '0;
            row <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a 2-cycle-latency BRAM model.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  char_v, attr_v;
  logic        valid;
  logic        ready;
  logic [7:0]  col;
  logic [5:0]  row;
  logic        busy;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  we;

  logic [31:0] mem [0:4095];
  logic [31:0] pipe1, pipe2;
  logic        preload_en;
  logic [11:0] preload_addr;
  logic [31:0] preload_data;
  logic        ff_arm;
  int          ff_cnt, ff_bad, hi_bad;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  text_console_writer #(.COLS(160), .ROWS(45), .READ_LATENCY(2)) dut (
    .clk_hdmi_in(clk), .rst_in(rst), .char_in(char_v), .attr_in(attr_v),
    .char_valid_in(valid), .char_ready_out(ready),
    .cursor_col_out(col), .cursor_row_out(row), .busy_out(busy),
    .mem_addr_out(addr), .mem_data_out(wdata),
    .mem_write_enable_out(we), .mem_data_in(rdata)
  );

  assign rdata = pipe2;

  always @(posedge clk) begin
    pipe1 <= mem[addr[11:0]];
    pipe2 <= pipe1;
    if (preload_en) mem[preload_addr] <= preload_data;
    for (int b = 0; b < 4; b++)
      if (we[b]) mem[addr[11:0]][8*b +: 8] <= wdata[8*b +: 8];
    if (addr[31:12] != 20'b0) hi_bad <= hi_bad + 1;
    if (!ff_arm) begin
      ff_cnt <= 0;
      ff_bad <= 0;
    end else if (we != 4'h0) begin
      if (addr != 32'(ff_cnt) || wdata != 32'h0 || we != 4'hF) ff_bad <= ff_bad + 1;
      ff_cnt <= ff_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    while (ready !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) check("ready_timeout", {31'b0, ready}, 32'd1);
  endtask

  // Returns #1 after the transfer edge, i.e. inside the CELL cycle.
  task automatic send(input logic [7:0] c, input logic [7:0] a);
    wait_ready(20000);
    @(negedge clk);
    valid  = 1'b1;
    char_v = c;
    attr_v = a;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic send_idle(input logic [7:0] c, input logic [7:0] a);
    send(c, a);
    wait_ready(20000);
  endtask

  initial begin
    int busy_n, nz;
    rst = 1'b1; valid = 1'b0; char_v = '0; attr_v = '0;
    preload_en = 1'b0; preload_addr = '0; preload_data = '0; ff_arm = 1'b0;
    hi_bad = 0;
    repeat (3) @(negedge clk);
    check("rst_we", {28'b0, we}, 32'h0);
    check("rst_addr", addr, 32'h0);
    check("rst_data", wdata, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_cursor", {18'b0, row, col}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'h1);

    // First printable: single write cycle, ready low for exactly one cycle
    send(8'h41, 8'h1F);
    @(negedge clk);
    check("a_addr", addr, 32'd0);
    check("a_data", wdata, 32'h1F411F41);
    check("a_we", {28'b0, we}, 32'h3);
    check("a_ready_low", {31'b0, ready}, 32'h0);
    @(negedge clk);
    check("a_ready_back", {31'b0, ready}, 32'h1);
    check("a_we_off", {28'b0, we}, 32'h0);
    check("a_cursor", {18'b0, row, col}, {18'b0, 6'd0, 8'd1});

    send(8'h42, 8'h07);
    @(negedge clk);
    check("b_addr", addr, 32'd0);
    check("b_we", {28'b0, we}, 32'hC);
    check("b_data_hi", {16'b0, wdata[31:16]}, 32'h0742);
    wait_ready(100);

    for (int i = 0; i < 157; i++) send_idle(8'h2E, 8'h07);
    check("col159", {18'b0, row, col}, {18'b0, 6'd0, 8'd159});
    send(8'h43, 8'h0F);
    @(negedge clk);
    check("wrap_addr", addr, 32'd79);
    check("wrap_we", {28'b0, we}, 32'hC);
    wait_ready(100);
    check("wrap_cursor", {18'b0, row, col}, {18'b0, 6'd1, 8'd0});

    // Control characters from (5,2)
    send_idle(8'h0A, 8'h00);
    for (int i = 0; i < 5; i++) send_idle(8'h61, 8'h07);
    check("at_5_2", {18'b0, row, col}, {18'b0, 6'd2, 8'd5});
    send(8'h0A, 8'h00);
    @(negedge clk);
    check("lf_no_write", {28'b0, we}, 32'h0);
    wait_ready(100);
    check("lf_cursor", {18'b0, row, col}, {18'b0, 6'd3, 8'd0});
    for (int i = 0; i < 7; i++) send_idle(8'h62, 8'h07);
    send(8'h0D, 8'h00);
    @(negedge clk);
    check("cr_no_write", {28'b0, we}, 32'h0);
    @(negedge clk);
    check("cr_ready_next", {31'b0, ready}, 32'h1);
    check("cr_cursor", {18'b0, row, col}, {18'b0, 6'd3, 8'd0});
    send_idle(8'h08, 8'h00);
    check("bs_col0", {18'b0, row, col}, {18'b0, 6'd3, 8'd0});
    send_idle(8'h63, 8'h07);
    send_idle(8'h08, 8'h00);
    check("bs_col1", {18'b0, row, col}, {18'b0, 6'd3, 8'd0});
    send(8'h07, 8'h00);
    @(negedge clk);
    check("bel_no_write", {28'b0, we}, 32'h0);
    wait_ready(100);
    check("bel_cursor", {18'b0, row, col}, {18'b0, 6'd3, 8'd0});

    // Scroll from row 44
    for (int i = 0; i < 41; i++) send_idle(8'h0A, 8'h00);
    check("row44", {18'b0, row, col}, {18'b0, 6'd44, 8'd0});
    @(negedge clk);
    preload_en = 1'b1; preload_addr = 12'd80; preload_data = 32'hDEADBEEF;
    @(negedge clk);
    preload_addr = 12'd3599; preload_data = 32'h12345678;
    @(negedge clk);
    preload_en = 1'b0;
    send(8'h0A, 8'h00);
    busy_n = 0;
    for (int g = 0; g < 20000; g++) begin
      @(negedge clk);
      if (busy) busy_n++;
      else if (busy_n > 0) break;
    end
    check("scroll_busy_cycles", 32'(busy_n), 32'd14160);
    check("scroll_ready", {31'b0, ready}, 32'h1);
    check("scroll_cursor", {18'b0, row, col}, {18'b0, 6'd44, 8'd0});
    check("scroll_word0", mem[0], 32'hDEADBEEF);
    check("scroll_word3519", mem[3519], 32'h12345678);
    nz = 0;
    for (int i = 3520; i < 3600; i++) if (mem[i] != 32'h0) nz++;
    check("scroll_blank_row", 32'(nz), 32'd0);

    // Form feed clears the whole screen
    ff_arm = 1'b1;
    send(8'h0C, 8'h00);
    wait_ready(5000);
    check("ff_writes", 32'(ff_cnt), 32'd3600);
    check("ff_seq_bad", 32'(ff_bad), 32'd0);
    check("ff_cursor", {18'b0, row, col}, 32'h0);
    check("ff_ready", {31'b0, ready}, 32'h1);
    ff_arm = 1'b0;

    // Reset asserted between edges during a scroll
    for (int i = 0; i < 44; i++) send_idle(8'h0A, 8'h00);
    send(8'h0A, 8'h00);
    repeat (100) @(posedge clk);
    #1 check("mid_scroll_busy", {31'b0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_we", {28'b0, we}, 32'h0);
    check("arst_busy", {31'b0, busy}, 32'h0);
    check("arst_cursor", {18'b0, row, col}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_ready", {31'b0, ready}, 32'h1);
    check("addr_hi_zero", 32'(hi_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Terminal-style character sink that turns a byte stream into text-mode cell writes on the CPU-side port of the 160x45-cell video BRAM, which the HDMI scan-out reads.
- Tracks a cursor and handles CR, LF, backspace and form feed.
- Scrolls the screen by word-wise copy when the cursor leaves the last row.
- Sits between a console source (UART bridge or CPU MMIO shim) and the video BRAM port B, which it owns exclusively.

Parameters:
COLS, 160, cells per row (2 cells per 32-bit word; 80 words per row)
ROWS, 45, rows on screen (total 3600 words)
READ_LATENCY, 2, cycles from mem_addr_out driven to mem_data_in valid (port B HIGH_PERFORMANCE)

Ports:
clk_hdmi_in  in  1  sole clock
rst_in  in  1  reset, asynchronous, active-high
char_in  in  8  byte to render/interpret
attr_in  in  8  attribute byte, sampled with char_in
char_valid_in  in  1  source has a byte
char_ready_out  out  1  block accepts a byte this cycle
cursor_col_out  out  8  current column, 0..159
cursor_row_out  out  6  current row, 0..44
busy_out  out  1  scroll or clear in progress
mem_addr_out  out  32  word address; bits [31:12] always 0
mem_data_out  out  32  write data
mem_write_enable_out  out  4  byte write enables
mem_data_in  in  32  port B read data

Behaviour:
- Async reset: state IDLE, cursor (0,0), mem_write_enable_out=0, mem_addr_out=0, mem_data_out=0, busy_out=0. char_ready_out=1 once reset is released.
- Cell layout: word = row*80 + col[7:1]. Even col uses bytes [7:0]=code, [15:8]=attr; odd col uses [23:16]=code, [31:24]=attr. Address arithmetic is 12-bit; max 3599.
- Handshake:
  - Transfer occurs when char_valid_in && char_ready_out.
  - char_ready_out is high only in IDLE.
  - char_in and attr_in are latched on transfer.
  - Peak throughput is 1 byte per 2 cycles.
- States: IDLE, CELL, SCROLL_RD, SCROLL_WAIT, SCROLL_WR, FILL.
- Decode of latched byte (IDLE -> next state):
  - 0x20..0x7E, 0x80..0xFF (printable) -> CELL.
    - For exactly one cycle: addr = cell word, data = {attr,code,attr,code}, we = 4'b0011 (even col) or 4'b1100 (odd col).
    - Then col+1.
    - If col was 159: col=0 and advance row (see newline).
  - 0x0A LF -> col=0, newline. No write.
  - 0x0D CR -> col=0. No write. Return to IDLE next cycle.
  - 0x08 BS -> col-1 if col>0, else unchanged. No erase.
  - 0x0C FF -> FILL over words 0..3599; cursor (0,0) on completion.
  - Any other byte <0x20 -> consumed, no write, no cursor change.
- Newline:
  - If row<44: row+1, return to IDLE.
  - If row==44: start scroll; row stays 44.
- Scroll, per word, for src = 80..3599 ascending with dst = src-80:
  - SCROLL_RD: drive src, we=0.
  - SCROLL_WAIT: hold src for READ_LATENCY cycles; capture mem_data_in at the end of the last wait cycle.
  - SCROLL_WR: drive dst with captured data, we=4'hF.
  - Cost: READ_LATENCY+2 cycles per word.
  - After word 3599, FILL words 3520..3599 with 0.
- FILL: one word per cycle, ascending address, data=0, we=4'hF.
- busy_out is high for the whole scroll and clear sequence; char_ready_out is low throughout.
- Total busy time: scroll+blank = 3520*(READ_LATENCY+2) + 80 cycles (14160 at default); FF clear = 3600 cycles.
- mem_write_enable_out is 0 in every state except CELL, SCROLL_WR and FILL.
- Reset mid-operation: aborts immediately. Memory is left partially updated with no restore; cursor goes to (0,0).
- A printable byte at (159,44) writes the cell, then scrolls; final cursor is (0,44).

Test Plan:
- Reset, send 0x41 with attr 0x1F -> one cycle addr=0, data=0x1F411F41, we=4'b0011; cursor (1,0); ready low exactly 1 cycle.
- Then send 0x42 attr 0x07 -> addr=0, we=4'b1100, data[31:16]=0x0742. Separately, printable at (159,0) -> addr=79, we=4'b1100, cursor (0,1).
- Cursor (5,2):
  - LF -> (0,3), no write.
  - CR at (7,3) -> (0,3).
  - BS at col 0 -> unchanged.
  - 0x07 -> consumed, no write.
- Model preloads word 80=0xDEADBEEF and word 3599=0x12345678; cursor row 44; send LF:
  - word 0=0xDEADBEEF, word 3519=0x12345678, words 3520..3599=0.
  - busy_out high 14160 cycles; cursor (0,44).
- Send 0x0C -> 3600 writes of 0, addresses 0..3599 consecutive, we=4'hF; then cursor (0,0), ready=1.
- Assert rst_in between clock edges mid-scroll -> we=0 and busy_out=0 before the next edge; cursor (0,0); ready=1 after release.
